// File: rtl/paint_px_writer_if.sv
// rtl/paint_px_writer_if.sv - paint strobe, framebuffer RAM port and status bundle for paint_px_writer
interface paint_px_writer_if #(
  parameter int DATA_W = 8
);
  logic              paint;
  logic [DATA_W-1:0] px_data;
  logic [7:0]        in_x;
  logic [7:0]        in_y;
  logic              src_done;
  logic              full;
  logic              mem_we;
  logic [11:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              frame_done;
  logic              overflow;
  logic [7:0]        drop_cnt;

  modport slave (
    input  paint, px_data, in_x, in_y, src_done, mem_ack,
    output full, mem_we, mem_addr, mem_wdata, frame_done, overflow, drop_cnt
  );

  modport master (
    output paint, px_data, in_x, in_y, src_done, mem_ack,
    input  full, mem_we, mem_addr, mem_wdata, frame_done, overflow, drop_cnt
  );
endinterface

// File: rtl/paint_px_writer.sv
// rtl/paint_px_writer.sv - buffers pixel paints and commits each as one framebuffer RAM write
// Optional macro PXW_BOUNDS_CHECK_EN: discard and count paints with x or y >= 64 instead of wrapping.
module paint_px_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  paint_px_writer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 12 + DATA_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t        state, state_nx;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          in_range, push, pop, fifo_empty, fifo_full;
  logic          pending, fire;
  logic [EW-1:0] head;

`ifdef PXW_BOUNDS_CHECK_EN
  assign in_range = (bus.in_x[7:6] == 2'b00) && (bus.in_y[7:6] == 2'b00);
`else
  logic unused_hi;
  assign in_range  = 1'b1;
  assign unused_hi = ^{bus.in_x[7:6], bus.in_y[7:6]};
`endif

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = bus.paint && in_range && !fifo_full;
  assign head       = fifo_mem[rd_ptr];
  assign fire       = pending && (state == S_IDLE) && fifo_empty;

  assign bus.full   = fifo_full;
  assign bus.mem_we = (state == S_WRITE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // A pop always feeds the address/data registers, so WRITE chains entries back-to-back.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          if (!fifo_empty) pop      = 1'b1;
          else             state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.in_y[5:0], bus.in_x[5:0], bus.px_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (pop) begin
      bus.mem_addr  <= head[EW-1:DATA_W];
      bus.mem_wdata <= head[DATA_W-1:0];
    end
  end

  // Overflow uses the registered count, so a pop on the same edge does not rescue the pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      bus.overflow <= 1'b0;
    else if (bus.paint && in_range && fifo_full)   bus.overflow <= 1'b1;
  end

  // Extra src_done pulses while a completion is already pending are absorbed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending        <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= fire;
      pending        <= fire ? 1'b0 : (pending | bus.src_done);
    end
  end

`ifdef PXW_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bus.drop_cnt <= '0;
    else if (bus.paint && !in_range && (bus.drop_cnt != 8'hFF))
      bus.drop_cnt <= bus.drop_cnt + 8'd1;
  end
`else
  assign bus.drop_cnt = 8'd0;
`endif
endmodule

// File: doc/paint_px_writer.md
# paint_px_writer

Framebuffer write stage sitting directly downstream of the cursor/palette drawing stage in the retro-paint datapath. It accepts that stage's pixel-paint strobes (8-bit coordinates plus 8-bit pixel data), buffers them in a small FIFO, and converts each into a single write on the 64x64 framebuffer RAM port, holding each write until the RAM acknowledges it. It signals completion of a drawing pass once the upstream stage reports done and every buffered pixel has been committed.

## Interface
- FIFO_DEPTH, 4: buffer entries; power of two, 2..16.
- DATA_W, 8: pixel data width.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- paint  in  1  pixel write strobe; one pixel per high cycle.
- px_data  in  DATA_W  pixel value, sampled with paint.
- in_x  in  8  column, sampled with paint.
- in_y  in  8  row, sampled with paint.
- src_done  in  1  upstream pass-complete pulse.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- mem_we  out  1  RAM write request, held until acknowledged.
- mem_addr  out  12  {y[5:0], x[5:0]}.
- mem_wdata  out  DATA_W  pixel value.
- mem_ack  in  1  RAM accepted the write on this edge.
- frame_done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky: a paint arrived while full.
- drop_cnt  out  8  out-of-range pixels discarded (saturating).

## Operation
- Reset (rst low, asynchronous): FIFO empty, count 0, state IDLE; mem_we 0, mem_addr 0, mem_wdata 0, full 0, frame_done 0, overflow 0, drop_cnt 0, pending flag 0.
- Push: on a rising edge with paint=1 and count<FIFO_DEPTH, {in_y[5:0], in_x[5:0], px_data} is written into the FIFO (subject to Configuration). With paint=1 and count==FIFO_DEPTH, the pixel is discarded and overflow is set; this holds even if a pop happens on the same edge.
- A push and a pop on the same edge leave count unchanged. full is decoded from the registered count.
- FSM has two states:
  - IDLE: mem_we=0. If the FIFO is non-empty, pop the head into the mem_addr/mem_wdata registers, set mem_we=1, go to WRITE.
  - WRITE: mem_we=1; mem_addr and mem_wdata are held stable.
    - On an edge with mem_ack=1 and FIFO non-empty: pop the next entry and stay in WRITE (back-to-back, mem_we stays 1).
    - On an edge with mem_ack=1 and FIFO empty: mem_we goes to 0, go to IDLE.
    - mem_ack=0: no change.
- Completion: src_done=1 on any edge sets pending. When pending=1, state is IDLE and the FIFO is empty, frame_done pulses for one cycle and pending clears. A src_done arriving while pending is already set is absorbed (one pulse only).
- Reset mid-write: mem_we drops immediately (asynchronously) and all buffered pixels are lost.

## Timing
- Latency: paint sampled at edge k with an empty FIFO and state IDLE gives mem_we=1 with the matching address after edge k+1.
- Throughput: with mem_ack tied high, one write commits per cycle.
- Completion: if the last write is acknowledged at edge m and pending=1, frame_done is high after edge m+1, for exactly one cycle.
- If src_done and the final ack occur on the same edge, pending is set on that edge and frame_done follows after the next edge.
- drop_cnt saturates at 255. overflow stays set until reset.

## Configuration
- PXW_BOUNDS_CHECK_EN defined:
  - A paint with in_x≥64 or in_y≥64 is not pushed.
  - drop_cnt increments (saturating).
  - The pixel does not set overflow, even when the FIFO is full.
- PXW_BOUNDS_CHECK_EN undefined:
  - Coordinates are truncated to bits [5:0], so they wrap.
  - Every in-range-or-not paint is pushed.
  - drop_cnt is constant 0.

## Test plan
- Reset: hold rst=0 → all outputs 0. Release, then paint x=10, y=20, data=0x5A at edge k, mem_ack=1 → mem_we=1, mem_addr=0x50A, mem_wdata=0x5A after edge k+1; mem_we=0 after k+2.
- Backpressure: mem_ack=0, paint 6 pixels on consecutive cycles, FIFO_DEPTH=4 → full=1, overflow=1. Raise mem_ack → exactly 5 writes (1 held + 4 buffered) commit, in order.
- Streaming: mem_ack=1, 8 consecutive paints → 8 consecutive mem_we cycles with no gaps, addresses matching inputs.
- Completion: src_done during the 3rd of 4 buffered writes → one frame_done pulse, one cycle after the 4th ack. A second src_done while pending → still one pulse.
- Bounds: paint x=70, y=5.
  - With PXW_BOUNDS_CHECK_EN: no write, drop_cnt=1.
  - Without it: write at mem_addr=0x146.
- Async reset during WRITE with 3 entries queued → mem_we=0 immediately. No further writes after release.
